// File: rtl/conv2d_stream_feeder_pkg.sv
// Shared definitions for the conv2d input feeder: FSM encoding, kernel size
// and the sizing helpers used to dimension its counters.
package conv2d_stream_feeder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_K_RD     = 3'd1,
    ST_K_WAIT   = 3'd2,
    ST_P_STREAM = 3'd3,
    ST_FLUSH    = 3'd4,
    ST_FIN      = 3'd5
  } feed_state_e;

  localparam int KTAPS = 9;

  // Bits needed to hold values 0..value-1; never narrower than one bit.
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // One extra beat beyond a full row drains the engine's double line buffer.
  function automatic int default_flush_len(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/conv2d_stream_feeder_addr_gen.sv
// Base + index read address generator; last_o flags the final index of a phase.
module feed_addr_gen #(
  parameter int ADDR_WIDTH = 16,
  parameter int BASE       = 0,
  parameter int COUNT      = 9,
  parameter int IDX_W      = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clr_i,
  input  logic                  adv_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_o
);

  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (adv_i) begin
      idx_d = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  // Address wraps naturally at ADDR_WIDTH.
  assign addr_o = ADDR_WIDTH'(BASE) + ADDR_WIDTH'(idx_q);
  assign last_o = (idx_q == IDX_W'(COUNT - 1));

endmodule

// File: rtl/conv2d_stream_feeder.sv
// Feeds one 3x3 conv engine: 9 kernel words, then the frame, then zero flush beats.
// Every memory read becomes an engine beat exactly one cycle later; pause only stalls new reads.
module conv2d_stream_feeder
  import conv2d_stream_feeder_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int WIDTH       = 32,
  parameter int HEIGHT      = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int KERNEL_BASE = 0,
  parameter int IMAGE_BASE  = 16,
  parameter int FLUSH_LEN   = default_flush_len(WIDTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  pause,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  load_kernel,
  output logic [31:0]           kernel,
  input  logic                  load_kernel_done,
  output logic                  data_valid_in,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  busy,
  output logic                  done
);

  localparam int NPIX   = WIDTH * HEIGHT;
  localparam int PIX_W  = clogb2(NPIX + 1);
  localparam int KIDX_W = clogb2(KTAPS + 1);
  localparam int FL_W   = clogb2(FLUSH_LEN + 1);

  feed_state_e     state_q;
  logic [FL_W-1:0] flush_q;
  logic            busy_q;
  logic            done_q;
  logic            load_kernel_q;
  logic            beat_v_q;
  logic            beat_zero_q;

  logic                  k_rd;
  logic                  p_rd;
  logic                  f_beat;
  logic                  k_last;
  logic                  p_last;
  logic                  k_clr;
  logic                  p_clr;
  logic [ADDR_WIDTH-1:0] k_addr;
  logic [ADDR_WIDTH-1:0] p_addr;

  // Kernel reads ignore pause so the engine always sees 9 contiguous words.
  assign k_rd   = (state_q == ST_K_RD);
  assign p_rd   = (state_q == ST_P_STREAM) && !pause;
  assign f_beat = (state_q == ST_FLUSH) && !pause;
  assign k_clr  = (state_q == ST_IDLE);
  assign p_clr  = (state_q == ST_IDLE) || (state_q == ST_K_WAIT);

  feed_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE       (KERNEL_BASE),
    .COUNT      (KTAPS),
    .IDX_W      (KIDX_W)
  ) u_k_addr (
    .clk    (clk),
    .resetn (resetn),
    .clr_i  (k_clr),
    .adv_i  (k_rd),
    .addr_o (k_addr),
    .last_o (k_last)
  );

  feed_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE       (IMAGE_BASE),
    .COUNT      (NPIX),
    .IDX_W      (PIX_W)
  ) u_p_addr (
    .clk    (clk),
    .resetn (resetn),
    .clr_i  (p_clr),
    .adv_i  (p_rd),
    .addr_o (p_addr),
    .last_o (p_last)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      flush_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      load_kernel_q <= 1'b0;
      beat_v_q      <= 1'b0;
      beat_zero_q   <= 1'b0;
    end else begin
      done_q        <= 1'b0;
      load_kernel_q <= k_rd;
      beat_v_q      <= p_rd || f_beat;
      beat_zero_q   <= f_beat;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            busy_q  <= 1'b1;
            state_q <= load_kernel_done ? ST_P_STREAM : ST_K_RD;
          end
        end
        ST_K_RD: begin
          if (k_last) state_q <= ST_K_WAIT;
        end
        ST_K_WAIT: begin
          if (load_kernel_done) state_q <= ST_P_STREAM;
        end
        ST_P_STREAM: begin
          if (p_rd && p_last) begin
            flush_q <= '0;
            state_q <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (f_beat) begin
            flush_q <= flush_q + FL_W'(1);
            if (flush_q == FL_W'(FLUSH_LEN - 1)) state_q <= ST_FIN;
          end
        end
        ST_FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Output stage: read data is passed straight through the cycle after the read.
  assign mem_rd_en     = k_rd || p_rd;
  assign mem_addr      = k_rd ? k_addr : (p_rd ? p_addr : '0);
  assign load_kernel   = load_kernel_q;
  assign kernel        = load_kernel_q ? 32'(mem_rdata) : 32'd0;
  assign data_valid_in = beat_v_q;
  assign data_in       = (beat_v_q && !beat_zero_q) ? mem_rdata : '0;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: doc/conv2d_stream_feeder.md
# conv2d_stream_feeder

Sequencer that drives the input side of the 3x3 floating-point convolution engine. It reads nine kernel words and one WIDTH×HEIGHT frame from a synchronous single-port memory. It serialises the kernel into the engine's `load_kernel`/`kernel` port. It then streams the pixels on `data_valid_in`/`data_in`, followed by zero flush beats so the engine's double line buffer drains the last row. It sits between the frame/weight RAM and the conv engine, and one instance drives each engine.

## Interface
Parameters:
- DATA_WIDTH, 32, pixel/kernel word width (IEEE-754 single)
- WIDTH, 32, frame width in pixels
- HEIGHT, 32, frame height in pixels
- ADDR_WIDTH, 16, memory address width
- KERNEL_BASE, 0, address of kernel word 0; words 0..8 are row-major
- IMAGE_BASE, 16, address of pixel (row 0, col 0); frame stored row-major
- FLUSH_LEN, WIDTH+1, number of zero beats appended after the frame

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request; sampled only in IDLE
- pause  in  1  holds off new pixel/flush reads while high
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_WIDTH  read address; data returns on mem_rdata one cycle later
- mem_rdata  in  DATA_WIDTH  read data
- load_kernel  out  1  kernel word valid to engine
- kernel  out  32  kernel word
- load_kernel_done  in  1  engine has latched all 9 words (sticky until engine reset)
- data_valid_in  out  1  pixel beat valid to engine
- data_in  out  DATA_WIDTH  pixel beat
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last flush beat

## Operation
- FSM states: IDLE, K_RD, K_WAIT, P_STREAM, FLUSH, FIN.
- IDLE:
  - On start with load_kernel_done=0, go to K_RD.
  - On start with load_kernel_done=1, go to P_STREAM and skip the kernel reload.
  - start in any other state is ignored.
- K_RD: issue 9 consecutive reads, KERNEL_BASE..KERNEL_BASE+8. pause is ignored. Then go to K_WAIT.
- Kernel delivery: each returned word drives load_kernel=1 and kernel=mem_rdata for exactly one cycle. This gives exactly 9 contiguous load_kernel cycles; the engine counts every asserted cycle, so no extra or missing pulses are allowed.
- K_WAIT: stay until load_kernel_done=1, then go to P_STREAM. There is no timeout.
- P_STREAM:
  - Address = IMAGE_BASE + idx, truncated to ADDR_WIDTH, with idx running 0..WIDTH*HEIGHT-1.
  - One read per cycle while pause=0; no read while pause=1.
  - After the read at idx=WIDTH*HEIGHT-1, go to FLUSH.
- FLUSH: issue FLUSH_LEN zero beats, one per cycle while pause=0. No memory read (mem_rd_en=0). Then go to FIN.
- FIN: done=1 for one cycle, busy drops, return to IDLE.
- Output stage:
  - Registered flags beat_v and beat_zero.
  - data_valid_in = beat_v.
  - data_in = beat_zero ? 0 : mem_rdata, so zero beats follow the last pixel in order.
- pause never drops or duplicates a beat; a read already issued is still delivered the next cycle.
- Counters:
  - idx is clogb2(WIDTH*HEIGHT+1) bits.
  - The flush counter is clogb2(FLUSH_LEN+1) bits.
  - Both clear on entry to their state.

## Timing
- Reset: all outputs 0, state IDLE, counters 0. This holds for reset asserted at any point, including mid-frame. Nothing resumes; a new start is required.
- start accepted in cycle 0:
  - busy=1 from cycle 1.
  - Kernel path: reads in cycles 1–9; load_kernel in cycles 2–10.
  - Skip path: first pixel read in cycle 1; first data_valid_in in cycle 2.
- Read-to-beat latency is exactly 1 cycle for both kernel and pixel beats.
- Without pause: last pixel beat is followed immediately by FLUSH_LEN zero beats. done is asserted the cycle after the last flush beat, with busy=0 in that same cycle.
- With pause high for N cycles, the beat stream has exactly an N-cycle gap.
- mem_rd_en and load_kernel are never both high while data_valid_in is high.

## Structure
- Shared conv package holds:
  - the FSM state encoding;
  - the clogb2 function;
  - the kernel size constant KTAPS=9;
  - default FLUSH_LEN.
- One sub-module, `feed_addr_gen`: base + index counter with terminal flag, instantiated for the kernel phase and the pixel phase.
- The output stage stays in the top module.

## Test plan
- Reset:
  - Assert resetn=0 → all outputs 0, state IDLE.
  - Release and hold start=0 for 20 cycles → no mem_rd_en.
- Kernel load:
  - Setup: RAM[0..8]=0x3F800000+k; engine model asserts done 1 cycle after the 9th word.
  - Stimulus: pulse start.
  - Required: load_kernel high in cycles 2–10 exactly; kernel equals RAM[0..8] in order.
- Full frame (WIDTH=HEIGHT=4, IMAGE_BASE=16):
  - Required: 16 beats equal to RAM[16..31] in order, then 5 zero beats, then done pulse once, then busy=0.
- Pause:
  - Stimulus: pause=1 for 3 cycles at pixel idx 6.
  - Required: exactly a 3-cycle gap in data_valid_in; 16 pixel beats total, no duplicates or omissions.
  - Repeat with pause during FLUSH → still 5 zero beats.
- Skip reload:
  - Stimulus: second start with load_kernel_done=1.
  - Required: no load_kernel; first data_valid_in at cycle 2.
- Reset and ignored start:
  - resetn pulsed low at pixel idx 9 → outputs 0 immediately; next start produces the full sequence from idx 0.
  - start during busy → ignored.
